instruction_decode: RTL

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

---
 rtl/instruction_decode.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instruction_decode.sv
// IF/ID pipeline register, MIPS-subset control decoder and 32x32 register file.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data onto bus_a/bus_b.
module instruction_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flush,
    input  logic        reg_wr_in,
    input  logic [4:0]  rw_in,
    input  logic [31:0] bus_w,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [25:0] target,
    output logic [31:0] bus_a,
    output logic [31:0] bus_b,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        memto_reg,
    output logic        reg_wr,
    output logic        mem_wr,
    output logic        branch,
    output logic        jump,
    output logic        ext_op,
    output logic [2:0]  alu_ctr,
    output logic        illegal
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [31:0] ir_reg;
    logic        valid_reg;
    logic [31:0] regfile_reg [32];

    assign out_valid = valid_reg;
    assign in_ready  = !valid_reg || out_ready;

    // Flush wins over capture; a consumed entry with nothing behind it empties the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            ir_reg    <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (in_valid && in_ready) begin
            ir_reg    <= instruction;
            valid_reg <= 1'b1;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // Register 0 never has a write enable, so it stays at its reset value of zero.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regfile_reg[gi] <= '0;
                end else if (reg_wr_in && rw_in == 5'(gi) && gi != 0) begin
                    regfile_reg[gi] <= bus_w;
                end
            end
        end
    endgenerate

    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign rd     = ir_reg[15:11];
    assign imm16  = ir_reg[15:0];
    assign target = ir_reg[25:0];

`ifdef ID_WB_BYPASS_EN
    assign bus_a = (reg_wr_in && rw_in == rs && rs != 5'd0) ? bus_w : regfile_reg[rs];
    assign bus_b = (reg_wr_in && rw_in == rt && rt != 5'd0) ? bus_w : regfile_reg[rt];
`else
    assign bus_a = regfile_reg[rs];
    assign bus_b = regfile_reg[rt];
`endif

    logic       reg_wr_d, mem_wr_d, branch_d, jump_d, illegal_d;

    always_comb begin
        reg_dst   = 1'b0;
        alu_src   = 1'b0;
        memto_reg = 1'b0;
        reg_wr_d  = 1'b0;
        mem_wr_d  = 1'b0;
        branch_d  = 1'b0;
        jump_d    = 1'b0;
        ext_op    = 1'b0;
        alu_ctr   = 3'b000;
        illegal_d = 1'b0;
        case (ir_reg[31:26])
            OP_RTYPE: begin
                reg_dst  = 1'b1;
                reg_wr_d = 1'b1;
                case (ir_reg[5:0])
                    6'b100000: alu_ctr = 3'b000;
                    6'b100010: alu_ctr = 3'b001;
                    6'b100100: alu_ctr = 3'b010;
                    6'b100101: alu_ctr = 3'b011;
                    6'b101010: alu_ctr = 3'b100;
                    6'b101011: alu_ctr = 3'b101;
                    default: begin
                        reg_dst   = 1'b0;
                        reg_wr_d  = 1'b0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: begin
                alu_src  = 1'b1;
                reg_wr_d = 1'b1;
                ext_op   = 1'b1;
            end
            OP_ORI: begin
                alu_src  = 1'b1;
                reg_wr_d = 1'b1;
                alu_ctr  = 3'b011;
            end
            OP_LW: begin
                alu_src   = 1'b1;
                memto_reg = 1'b1;
                reg_wr_d  = 1'b1;
                ext_op    = 1'b1;
            end
            OP_SW: begin
                alu_src  = 1'b1;
                mem_wr_d = 1'b1;
                ext_op   = 1'b1;
            end
            OP_BEQ: begin
                branch_d = 1'b1;
                alu_ctr  = 3'b001;
            end
            OP_J:    jump_d    = 1'b1;
            default: illegal_d = 1'b1;
        endcase
    end

    // State-changing controls only reach execute alongside a valid instruction.
    assign reg_wr  = valid_reg && reg_wr_d;
    assign mem_wr  = valid_reg && mem_wr_d;
    assign branch  = valid_reg && branch_d;
    assign jump    = valid_reg && jump_d;
    assign illegal = valid_reg && illegal_d;

endmodule
